// File: rtl/fifo_rd_arbiter.sv
// Round-robin read scheduler: drains NCH show-ahead async-FIFO read ports into one
// registered valid/ready stream, keeping a grant for up to BURST pops.

module fifo_rd_arbiter_lane (
  input  logic sel,
  input  logic empty,
  input  logic mask,
  input  logic pop_en,
  output logic req,
  output logic rinc
);
  assign req  = mask & ~empty;
  assign rinc = sel & req & pop_en;
endmodule

module fifo_rd_arbiter #(
  parameter int DSIZE = 8,
  parameter int NCH   = 4,
  parameter int CHW   = 2,
  parameter int BURST = 4
) (
  input  logic                 rclk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       ch_empty,
  input  logic [NCH*DSIZE-1:0] ch_rdata,
  input  logic [NCH-1:0]       ch_mask,
  output logic [NCH-1:0]       ch_rinc,
  output logic                 out_valid,
  output logic [DSIZE-1:0]     out_data,
  output logic [CHW-1:0]       out_ch,
  input  logic                 out_ready,
  output logic                 busy,
  output logic [CHW-1:0]       gnt_id
);
  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state;
  logic [CHW-1:0]   rr_ptr;
  logic [7:0]       beat_cnt;
  logic [NCH-1:0]   req, sel;
  logic             pop_en, pop, g_req, found;
  logic [CHW-1:0]   off, pick, g_nxt;
  logic [CHW:0]     sum;
  logic [2*NCH-1:0] req2;
  logic [NCH-1:0]   rot;
  logic [DSIZE-1:0] g_data;

  // rst_n gates the pop strobe so a mid-burst reset silences ch_rinc at once
  assign pop_en = rst_n && (state == GRANT) && (!out_valid || out_ready);

  for (genvar c = 0; c < NCH; c++) begin : g_lane
    assign sel[c] = (gnt_id == CHW'(c));
    fifo_rd_arbiter_lane u_lane (
      .sel   (sel[c]),
      .empty (ch_empty[c]),
      .mask  (ch_mask[c]),
      .pop_en(pop_en),
      .req   (req[c]),
      .rinc  (ch_rinc[c])
    );
  end

  assign g_req = |(req & sel);
  assign pop   = pop_en & g_req;

  always_comb begin
    g_data = '0;
    for (int c = 0; c < NCH; c++)
      if (sel[c]) g_data = ch_rdata[c*DSIZE +: DSIZE];
  end

  // rotate requests so bit 0 is rr_ptr, then take the lowest set bit
  assign req2 = {req, req} >> rr_ptr;
  assign rot  = req2[NCH-1:0];

  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int i = NCH-1; i >= 0; i--)
      if (rot[i]) begin
        found = 1'b1;
        off   = CHW'(i);
      end
  end

  assign sum   = {1'b0, rr_ptr} + {1'b0, off};
  assign pick  = (sum >= (CHW+1)'(NCH)) ? CHW'(sum - (CHW+1)'(NCH)) : sum[CHW-1:0];
  assign g_nxt = (gnt_id == CHW'(NCH-1)) ? '0 : gnt_id + 1'b1;

  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      gnt_id    <= '0;
      beat_cnt  <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else begin
      if (pop) begin
        out_valid <= 1'b1;
        out_data  <= g_data;
        out_ch    <= gnt_id;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: if (found) begin
          state    <= GRANT;
          busy     <= 1'b1;
          gnt_id   <= pick;
          beat_cnt <= '0;
        end
        GRANT: begin
          // empty or unmasked channel releases without a pop; stalls keep the grant
          if (!g_req || (pop && beat_cnt == 8'(BURST-1))) begin
            state  <= IDLE;
            busy   <= 1'b0;
            rr_ptr <= g_nxt;
          end else if (pop) begin
            beat_cnt <= beat_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
